// File: rtl/jtframe_68kdma_pkg.sv
// jtframe_68kdma_pkg: shared state encoding and channel limit for the 68k DMA arbiter
package jtframe_68kdma_pkg;
  localparam int MAXCH = 8;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_GAP} state_t;
endpackage

// File: rtl/jtframe_rr_pick.sv
// jtframe_rr_pick: combinational picker, lowest index or rotating from a start index
module jtframe_rr_pick #(
  parameter  int CH = 2,
  localparam int IW = CH > 1 ? $clog2(CH) : 1
) (
  input  logic [CH-1:0] req_i,
  input  logic [IW-1:0] start_i,
  input  logic          rr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    int base, j;
    logic [CH-1:0] rot;
    idx_o   = '0;
    valid_o = 1'b0;
    base    = rr_i ? int'(start_i) : 0;
    for (int i = CH - 1; i >= 0; i--) begin
      j   = (base + i) % CH;
      rot = req_i >> j;
      if (rot[0]) begin
        idx_o   = IW'(j);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jtframe_68kdma_arb.sv
// jtframe_68kdma_arb: BR/BG/BGACK handshake on behalf of CH DMA masters, one owner per tenure
module jtframe_68kdma_arb
  import jtframe_68kdma_pkg::*;
#(
  parameter  int CH      = 2,
  parameter  int RR      = 0,
  parameter  int MAXHOLD = 0,
  parameter  int GAP     = 1,
  localparam int IW      = CH > 1 ? $clog2(CH) : 1,
  localparam int HW      = MAXHOLD == 0 ? 1 : $clog2(MAXHOLD + 1),
  localparam int GW      = $clog2(GAP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  output logic          cpu_BRn,
  output logic          cpu_BGACKn,
  input  logic          cpu_BGn,
  input  logic          cpu_ASn,
  input  logic          cpu_DTACKn,
  input  logic [CH-1:0] dev_br,
  output logic [CH-1:0] dev_bg,
  output logic          busy
);
  state_t        state_q, state_d;
  logic          brn_q, brn_d, bgackn_q, bgackn_d;
  logic [CH-1:0] bg_q, bg_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, start, pick_idx;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pick_v, hit, own_req;

  assign start   = (int'(last_q) == CH - 1) ? '0 : last_q + 1'b1;
  assign hit     = (MAXHOLD != 0) && (int'(hold_q) == MAXHOLD - 1);
  assign own_req = dev_br[owner_q];

  jtframe_rr_pick #(.CH(CH)) u_pick (
    .req_i  (dev_br),
    .start_i(start),
    .rr_i   (RR != 0),
    .idx_o  (pick_idx),
    .valid_o(pick_v)
  );

  always_comb begin
    state_d  = state_q;
    brn_d    = brn_q;
    bgackn_d = bgackn_q;
    bg_d     = bg_q;
    owner_d  = owner_q;
    last_d   = last_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    if (cen) case (state_q)
      S_IDLE: if (pick_v) begin
        brn_d   = 1'b0;
        state_d = S_REQ;
      end
      S_REQ: if (!pick_v) begin
        brn_d   = 1'b1;
        state_d = S_IDLE;
      end else if (!cpu_BGn && cpu_ASn && cpu_DTACKn) begin
        bgackn_d = 1'b0;
        brn_d    = 1'b1;
        owner_d  = pick_idx;
        last_d   = pick_idx;
        bg_d     = CH'(1) << pick_idx;
        hold_d   = '0;
        state_d  = S_OWN;
      end
      S_OWN: begin
        hold_d = &hold_q ? hold_q : hold_q + 1'b1;
        // other channels never pre-empt: only the owner's own request or the limit ends a tenure
        if (!own_req || hit) begin
          bgackn_d = 1'b1;
          bg_d     = '0;
          gap_d    = '0;
          state_d  = S_GAP;
        end
      end
      default: begin
        gap_d   = gap_q + 1'b1;
        state_d = (int'(gap_q) == GAP - 1) ? S_IDLE : S_GAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      brn_q    <= 1'b1;
      bgackn_q <= 1'b1;
      bg_q     <= '0;
      owner_q  <= '0;
      last_q   <= IW'(CH - 1);
      hold_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      brn_q    <= brn_d;
      bgackn_q <= bgackn_d;
      bg_q     <= bg_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
    end

  assign cpu_BRn    = brn_q;
  assign cpu_BGACKn = bgackn_q;
  assign dev_bg     = bg_q;
  assign busy       = !bgackn_q;
endmodule

// File: tb/tb_jtframe_68kdma_arb.sv
// tb_jtframe_68kdma_arb: three arbiter configurations checked against a tenure-level reference model
module tb_jtframe_68kdma_arb;
  localparam int P_CH[3] = '{2, 2, 3};
  localparam int P_RR[3] = '{0, 1, 1};
  localparam int P_MH[3] = '{3, 4, 0};
  localparam int P_GP[3] = '{1, 2, 1};

  logic clk = 0, rst_n = 0, cen = 1, asn = 1, dtackn = 1;
  logic bgn[3];
  logic [2:0] br[3];
  logic brn0, brn1, brn2, ack0, ack1, ack2, busy0, busy1, busy2;
  logic [1:0] bg0, bg1;
  logic [2:0] bg2;
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0, cdiv = 0;
  int m_brn[3], m_ack[3], m_own[3], m_last[3], m_held[3], m_cool[3];

  always #5 clk = ~clk;

  jtframe_68kdma_arb #(.CH(2), .RR(0), .MAXHOLD(3), .GAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_BRn(brn0), .cpu_BGACKn(ack0), .cpu_BGn(bgn[0]),
    .cpu_ASn(asn), .cpu_DTACKn(dtackn), .dev_br(br[0][1:0]), .dev_bg(bg0), .busy(busy0));
  jtframe_68kdma_arb #(.CH(2), .RR(1), .MAXHOLD(4), .GAP(2)) u1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_BRn(brn1), .cpu_BGACKn(ack1), .cpu_BGn(bgn[1]),
    .cpu_ASn(asn), .cpu_DTACKn(dtackn), .dev_br(br[1][1:0]), .dev_bg(bg1), .busy(busy1));
  jtframe_68kdma_arb #(.CH(3), .RR(1), .MAXHOLD(0), .GAP(1)) u2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_BRn(brn2), .cpu_BGACKn(ack2), .cpu_BGn(bgn[2]),
    .cpu_ASn(asn), .cpu_DTACKn(dtackn), .dev_br(br[2]), .dev_bg(bg2), .busy(busy2));

  function automatic logic o_brn(int k);
    return k == 0 ? brn0 : k == 1 ? brn1 : brn2;
  endfunction
  function automatic logic o_ack(int k);
    return k == 0 ? ack0 : k == 1 ? ack1 : ack2;
  endfunction
  function automatic logic o_busy(int k);
    return k == 0 ? busy0 : k == 1 ? busy1 : busy2;
  endfunction
  function automatic logic [2:0] o_bg(int k);
    return k == 0 ? {1'b0, bg0} : k == 1 ? {1'b0, bg1} : bg2;
  endfunction

  function automatic int pick(int k, int req);
    for (int i = 1; i <= P_CH[k]; i++) begin
      int c;
      c = P_RR[k] != 0 ? (m_last[k] + i) % P_CH[k] : i - 1;
      if (((req >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset(int k);
    m_brn[k] = 1; m_ack[k] = 1; m_own[k] = -1; m_last[k] = P_CH[k] - 1; m_held[k] = 0; m_cool[k] = 0;
  endtask

  task automatic model_step(int k);
    int req, w;
    req = int'(br[k]) & ((1 << P_CH[k]) - 1);
    if (!rst_n) begin model_reset(k); return; end
    if (!cen) return;
    if (m_own[k] >= 0) begin
      m_held[k]++;
      if (((req >> m_own[k]) & 1) == 0 || (P_MH[k] != 0 && m_held[k] == P_MH[k])) begin
        m_own[k] = -1; m_ack[k] = 1; m_cool[k] = P_GP[k];
      end
    end else if (m_cool[k] > 0) m_cool[k]--;
    else if (m_brn[k] == 0) begin
      if (req == 0) m_brn[k] = 1;
      else if (!bgn[k] && asn && dtackn) begin
        w = pick(k, req);
        m_own[k] = w; m_last[k] = w; m_ack[k] = 0; m_brn[k] = 1; m_held[k] = 0;
      end
    end else if (req != 0) m_brn[k] = 0;
  endtask

  task automatic tick();
    cen = cdiv ? (cyc % 3 == 0) : cen;
    cyc++;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic auto_tick();
    for (int k = 0; k < 3; k++) bgn[k] = o_brn(k);
    tick();
  endtask

  always @(negedge clk) if (mon_en) for (int k = 0; k < 3; k++) begin
    logic [2:0] ebg;
    ebg = m_own[k] >= 0 ? 3'(1 << m_own[k]) : 3'd0;
    checks += 5;
    if (o_brn(k) !== 1'(m_brn[k])) begin errors++; $display("FAIL mon_brn u%0d t=%0t got %b want %0d", k, $time, o_brn(k), m_brn[k]); end
    if (o_ack(k) !== 1'(m_ack[k])) begin errors++; $display("FAIL mon_bgackn u%0d t=%0t got %b want %0d", k, $time, o_ack(k), m_ack[k]); end
    if (o_bg(k) !== ebg) begin errors++; $display("FAIL mon_bg u%0d t=%0t got %b want %b", k, $time, o_bg(k), ebg); end
    if (o_busy(k) !== (m_ack[k] == 0)) begin errors++; $display("FAIL mon_busy u%0d t=%0t got %b want %b", k, $time, o_busy(k), m_ack[k] == 0); end
    if (!o_brn(k) && !o_ack(k)) begin errors++; $display("FAIL mon_br_bgack_both u%0d t=%0t got 00 want not 00", k, $time); end
  end

  task automatic do_reset();
    mon_en = 0; rst_n = 0; cen = 1; cdiv = 0; asn = 1; dtackn = 1;
    for (int k = 0; k < 3; k++) begin bgn[k] = 1; br[k] = 0; model_reset(k); end
    tick(); tick();
    rst_n = 1; mon_en = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_brn(k), o_ack(k), o_busy(k), o_bg(k)} !== 6'b110000) begin
        errors++; $display("FAIL reset u%0d got brn/bgackn/busy/bg=%b%b%b/%b want 110/000", k, o_brn(k), o_ack(k), o_busy(k), o_bg(k));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 3; k++) br[k] = 3'b001;
    tick();
    checks++; if (brn0 !== 1'b0) begin errors++; $display("FAIL single_brn_low got %b want 0", brn0); end
    tick();
    for (int k = 0; k < 3; k++) bgn[k] = 0;
    tick();
    checks++; if ({ack0, brn0, bg0} !== 4'b0101) begin errors++; $display("FAIL single_grant got bgackn/brn/bg=%b%b/%b want 01/01", ack0, brn0, bg0); end
    for (int k = 0; k < 3; k++) bgn[k] = 1;
    tick();
    for (int k = 0; k < 3; k++) br[k] = 3'b000;
    tick();
    checks++; if ({ack0, bg0} !== 3'b100) begin errors++; $display("FAIL single_release got bgackn/bg=%b/%b want 1/00", ack0, bg0); end
    repeat (4) tick();
  endtask

  task automatic test_busy_grant();
    do_reset();
    for (int k = 0; k < 3; k++) br[k] = 3'b001;
    tick();
    for (int k = 0; k < 3; k++) bgn[k] = 0;
    asn = 0;
    repeat (3) begin
      tick();
      checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL busy_as_low got bgackn=%b want 1", ack0); end
    end
    asn = 1; dtackn = 0;
    tick();
    checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL busy_dtack_low got bgackn=%b want 1", ack2); end
    dtackn = 1;
    tick();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL busy_grant got bgackn=%b want 0", ack0); end
    for (int k = 0; k < 3; k++) begin bgn[k] = 1; br[k] = 0; end
    repeat (5) tick();
  endtask

  task automatic test_priority();
    int q0[$], q1[$], q2[$];
    int e0[3] = '{1, 1, 1};
    int e1[3] = '{1, 2, 1};
    int e2[4] = '{1, 2, 4, 1};
    logic [2:0] prev[3];
    int n = 0;
    do_reset();
    br[0] = 3'b011; br[1] = 3'b011; br[2] = 3'b111;
    prev = '{3'd0, 3'd0, 3'd0};
    while ((q0.size() < 3 || q1.size() < 3 || q2.size() < 4) && n < 400) begin
      br[2] = 3'b111 & ~o_bg(2);
      auto_tick(); n++;
      if (prev[0] == 0 && o_bg(0) != 0) q0.push_back(int'(o_bg(0)));
      if (prev[1] == 0 && o_bg(1) != 0) q1.push_back(int'(o_bg(1)));
      if (prev[2] == 0 && o_bg(2) != 0) q2.push_back(int'(o_bg(2)));
      for (int k = 0; k < 3; k++) prev[k] = o_bg(k);
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL priority_timeout got %0d cycles want <400", n); end
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (q0.size() <= i || q0[i] != e0[i]) begin errors++; $display("FAIL prio_fixed tenure%0d got %0d want %0d", i, q0.size() > i ? q0[i] : -1, e0[i]); end
      if (q1.size() <= i || q1[i] != e1[i]) begin errors++; $display("FAIL prio_rr tenure%0d got %0d want %0d", i, q1.size() > i ? q1[i] : -1, e1[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q2.size() <= i || q2[i] != e2[i]) begin errors++; $display("FAIL prio_rr3 tenure%0d got %0d want %0d", i, q2.size() > i ? q2[i] : -1, e2[i]); end
    end
  endtask

  task automatic measure_hold(input bit div, input int want_bg, input int want_gap);
    int n = 0;
    do_reset();
    cdiv = div; cyc = 0;
    br[1] = 3'b001;
    while (bg1 == 0 && n < 60) begin auto_tick(); n++; end
    n = 0;
    while (bg1 != 0 && n < 60) begin n++; auto_tick(); end
    checks++; if (n != want_bg) begin errors++; $display("FAIL hold_len div=%0d got %0d want %0d", div, n, want_bg); end
    n = 0;
    while (ack1 && n < 60) begin n++; auto_tick(); end
    checks++; if (n != want_gap) begin errors++; $display("FAIL hold_gap div=%0d got %0d want %0d", div, n, want_gap); end
    checks++; if (bg1 !== 2'b01) begin errors++; $display("FAIL hold_regrant div=%0d got %b want 01", div, bg1); end
    cdiv = 0; cen = 1;
  endtask

  task automatic test_abort();
    do_reset();
    for (int k = 0; k < 3; k++) br[k] = 3'b010;
    tick();
    checks++; if (brn1 !== 1'b0) begin errors++; $display("FAIL abort_req got brn=%b want 0", brn1); end
    for (int k = 0; k < 3; k++) br[k] = 3'b000;
    tick();
    checks++; if ({brn1, ack1, bg1} !== 4'b1100) begin errors++; $display("FAIL abort got brn/bgackn/bg=%b%b/%b want 11/00", brn1, ack1, bg1); end
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    for (int k = 0; k < 3; k++) br[k] = 3'b001;
    while (bg2 == 0 && n < 50) begin auto_tick(); n++; end
    auto_tick();
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_brn(k), o_ack(k), o_bg(k)} !== 5'b11000) begin
        errors++; $display("FAIL async_reset u%0d got brn/bgackn/bg=%b%b/%b want 11/000", k, o_brn(k), o_ack(k), o_bg(k));
      end
      model_reset(k);
    end
    rst_n = 1;
    for (int k = 0; k < 3; k++) br[k] = 3'b011;
    n = 0;
    while (bg2 == 0 && n < 50) begin auto_tick(); n++; end
    checks++; if (bg2 !== 3'b001) begin errors++; $display("FAIL async_rr_restart got %b want 001", bg2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(7) == 0) br[k] = 3'($urandom);
        bgn[k] = $urandom_range(3) != 0 ? o_brn(k) : 1'($urandom);
      end
      asn = $urandom_range(4) != 0; dtackn = $urandom_range(4) != 0; cen = $urandom_range(3) != 0;
      tick();
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 0;
        #1 for (int k = 0; k < 3; k++) model_reset(k);
        rst_n = 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_grant();
    test_priority();
    measure_hold(0, 4, 4);
    measure_hold(1, 12, 12);
    test_abort();
    test_async_reset();
    test_random();
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
